dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester access controller for the 1 KB byte-addressed data memory (byte-lane memory with word access and lb/sb single-byte modes).
- Arbitrates the CPU data port (m0) against a loader/debug port (m1) with round-robin priority.
- Checks alignment and splits halfword accesses into two byte accesses.
- Performs sign/zero extension itself; the memory's lb sign-extension is not relied upon.
- Sits between the datapath/loader and dm_1k; it is the only driver of the memory's addr/din/we/islb/issb.

Parameters:
- ADDR_W, 10, memory byte-address width; memory depth is 2^ADDR_W bytes.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- mN_req  in  1  (N=0,1) request; sampled only in IDLE.
- mN_we  in  1  1=write, 0=read.
- mN_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- mN_sext  in  1  read sign-extend (1) or zero-extend (0); ignored for word.
- mN_addr  in  ADDR_W  byte address.
- mN_wdata  in  32  write data, little-endian lanes.
- mN_gnt  out  1  one-cycle pulse: request fields captured.
- mN_done  out  1  one-cycle pulse: access complete.
- mN_err  out  1  valid with done: misaligned or illegal size.
- mN_rdata  out  32  registered read result.
- dm_addr  out  ADDR_W  memory address.
- dm_din  out  32  memory write data.
- dm_we  out  1  memory write enable.
- dm_islb  out  1  byte-read select.
- dm_issb  out  1  byte-write select.
- dm_dout  in  32  memory read data (combinational from dm_addr).

Behaviour:
- Reset values:
  - State IDLE; round-robin pointer favours m0.
  - All gnt/done/err = 0; all rdata = 0.
  - dm_* outputs = 0.
  - dm_we is gated by ~rst, so no write occurs on a reset edge, including mid-operation. An aborted half write may leave only the low byte written.
- FSM states: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - If any req: pick the winner. With both requesting, the requester not granted last wins.
  - Winner gets mN_gnt=1 this cycle. Latch we/size/sext/addr/wdata and the owner id; the pointer then favours the other requester.
  - Error check at latch: size=11, or half with addr[0]=1, or word with addr[1:0]!=0. On error: go to DONE with err flag, no memory access.
  - Otherwise go to ACC0.
- ACC0: drive the memory from latched fields.
  - Byte: dm_addr=addr, islb=1 (read) or issb=1 (write), din[7:0]=wdata[7:0].
  - Word: dm_addr=addr, islb=issb=0, din=wdata.
  - Half: byte access at addr with wdata[7:0].
  - dm_we=latched we. Read bytes are captured from dm_dout[7:0] (word: all 32 bits) into an internal register.
  - Next state: ACC1 if half, else DONE.
- ACC1 (half only): byte access at addr+1 with wdata[15:8]; capture the high byte; go to DONE.
- DONE:
  - Owner's done=1 and err=latched error; go to IDLE.
  - For a read without error, owner's rdata is updated on this edge: byte = ext(b0); half = ext({b1,b0}); word as read. ext = sign- or zero-extension per sext.
  - Writes and errors leave rdata unchanged. The non-owner's rdata is never touched.
- Latency, req sampled at cycle t:
  - gnt at t.
  - done at t+2 for byte/word, t+3 for half, t+1 for error.
- Requests arriving while not in IDLE are not queued; req must stay high until gnt.
- Request fields may change after gnt.
- A req held high through done is re-arbitrated in the next IDLE cycle, where the other requester has priority.
- Outside ACC0/ACC1, all dm_* outputs = 0.

Decomposition:
- Shared header dm_defs.vh holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - FSM state encodings ST_IDLE/ST_ACC0/ST_ACC1/ST_DONE.
- One sub-module: rr_arb2 (2-way round-robin pick).
  - Inputs: req[1:0], pointer, advance.
  - Outputs: one-hot gnt[1:0], pointer register.

Test Plan:
- Word write then read: m0 writes 0xDEADBEEF at addr 0x010, then reads 0x010 → done at t+2 each; m0_rdata=0xDEADBEEF; memory bytes 0x010..0x013 = EF,BE,AD,DE.
- Byte sext/zext: byte at 0x020 = 0x80; read with sext=1 → rdata 0xFFFFFF80; read with sext=0 → rdata 0x00000080.
- Half split: m1 writes half 0x1234 at 0x042 → two dm_we cycles (addr 0x042 data 0x34, addr 0x043 data 0x12), done at t+3; read with sext=1 → rdata 0x00001234.
- Contention: m0 and m1 both hold req continuously with word reads → grants alternate m0, m1, m0, …; each done goes only to its owner; non-owner rdata unchanged.
- Errors: word at 0x101, half at 0x003, size=11 → done+err at t+1, dm_we never asserted, rdata unchanged.
- Reset mid-half-write: rst asserted in ACC1 → no write on that edge; state IDLE; all outputs 0; byte at addr+1 unchanged.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes, FSM
// state encoding and the alignment check applied when a request is latched.
package dm_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_DONE = 2'b11
    } dm_state_t;

    // Illegal size, odd halfword or non-word-aligned word access.
    function automatic logic f_bad_access(input logic [1:0] size, input logic [1:0] lsb);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && lsb[0]) ||
               ((size == SZ_WORD) && (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin picker. The pointer names the requester favoured on a
// tie and flips to the other side whenever a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt,
    output logic       o_ptr
);

    logic r_ptr;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_gnt[0];
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/dm_arbiter.sv
// Two-port access controller for the byte-lane data memory: round-robin
// arbitration, alignment checking, halfword splitting and read extension.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic              m0_sext,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic              m0_err,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic              m1_sext,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic              m1_err,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    output logic              dm_islb,
    output logic              dm_issb,
    input  logic [31:0]       dm_dout
);

    dm_state_t         r_state;
    dm_state_t         w_next;

    logic [1:0]        w_req;
    logic [1:0]        w_pick;
    logic              w_ptr;
    logic              w_adv;
    logic              w_win;

    logic              w_sel_we;
    logic [1:0]        w_sel_size;
    logic              w_sel_sext;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_bad;

    logic              r_owner;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_rbuf;
    logic [31:0]       r_rdata0;
    logic [31:0]       r_rdata1;
    logic              w_done;

    // Read extension is done here; the memory's own lb extension is ignored.
    function automatic logic [31:0] f_extend(input logic [31:0] raw, input logic [1:0] size,
                                             input logic sext);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = sext ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            SZ_HALF: res = sext ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign w_req = {m1_req, m0_req};
    assign w_adv = (r_state == ST_IDLE) && (|w_req) && !rst;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_req),
        .i_advance (w_adv),
        .o_gnt     (w_pick),
        .o_ptr     (w_ptr)
    );

    assign w_win       = w_pick[1];
    assign w_sel_we    = w_win ? m1_we    : m0_we;
    assign w_sel_size  = w_win ? m1_size  : m0_size;
    assign w_sel_sext  = w_win ? m1_sext  : m0_sext;
    assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;
    assign w_sel_bad   = f_bad_access(w_sel_size, w_sel_addr[1:0]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (|w_req) w_next = w_sel_bad ? ST_DONE : ST_ACC0;
            ST_ACC0: w_next = (r_size == SZ_HALF) ? ST_ACC1 : ST_DONE;
            ST_ACC1: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request fields are held here so the requester may change them after gnt.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_owner <= w_win;
            r_we    <= w_sel_we;
            r_size  <= w_sel_size;
            r_sext  <= w_sel_sext;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_err   <= w_sel_bad;
        end
    end

    always_comb begin
        dm_addr = '0;
        dm_din  = 32'h0;
        dm_we   = 1'b0;
        dm_islb = 1'b0;
        dm_issb = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_ACC0: begin
                    dm_addr = r_addr;
                    dm_we   = r_we;
                    if (r_size == SZ_WORD) begin
                        dm_din = r_wdata;
                    end else begin
                        dm_din  = {24'h0, r_wdata[7:0]};
                        dm_islb = ~r_we;
                        dm_issb = r_we;
                    end
                end
                ST_ACC1: begin
                    dm_addr = r_addr + ADDR_W'(1);
                    dm_we   = r_we;
                    dm_din  = {24'h0, r_wdata[15:8]};
                    dm_islb = ~r_we;
                    dm_issb = r_we;
                end
                default: ;
            endcase
        end
    end

    // Byte reads keep only lane 0; the high half of a split read lands in [15:8].
    always_ff @(posedge clk) begin
        if (r_state == ST_ACC0) begin
            r_rbuf <= (r_size == SZ_WORD) ? dm_dout : {24'h0, dm_dout[7:0]};
        end else if (r_state == ST_ACC1) begin
            r_rbuf[15:8] <= dm_dout[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
        end else if ((r_state == ST_DONE) && !r_err && !r_we) begin
            if (r_owner) begin
                r_rdata1 <= f_extend(r_rbuf, r_size, r_sext);
            end else begin
                r_rdata0 <= f_extend(r_rbuf, r_size, r_sext);
            end
        end
    end

    assign w_done   = (r_state == ST_DONE) && !rst;
    assign m0_gnt   = w_adv && w_pick[0];
    assign m1_gnt   = w_adv && w_pick[1];
    assign m0_done  = w_done && !r_owner;
    assign m1_done  = w_done && r_owner;
    assign m0_err   = m0_done && r_err;
    assign m1_err   = m1_done && r_err;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 1 KB byte-lane memory.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_sext, m0_gnt, m0_done, m0_err;
    logic [1:0]  m0_size;
    logic [9:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_sext, m1_gnt, m1_done, m1_err;
    logic [1:0]  m1_size;
    logic [9:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;
    logic        dm_we, dm_islb, dm_issb;

    dm_arbiter #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sext(m0_sext),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done),
        .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sext(m1_sext),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done),
        .m1_err(m1_err), .m1_rdata(m1_rdata),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_islb(dm_islb),
        .dm_issb(dm_issb), .dm_dout(dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: lb returns a sign-extended byte, otherwise a little-endian word.
    logic [7:0] mem [0:1023];
    logic       tb_clr;
    logic [9:0] a1, a2, a3;
    assign a1 = dm_addr + 10'd1;
    assign a2 = dm_addr + 10'd2;
    assign a3 = dm_addr + 10'd3;

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (dm_we) begin
            mem[dm_addr] <= dm_din[7:0];
            if (!dm_issb) begin
                mem[a1] <= dm_din[15:8];
                mem[a2] <= dm_din[23:16];
                mem[a3] <= dm_din[31:24];
            end
        end
    end

    always_comb begin
        if (dm_islb) dm_dout = {{24{mem[dm_addr][7]}}, mem[dm_addr]};
        else         dm_dout = {mem[a3], mem[a2], mem[a1], mem[dm_addr]};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic rq, input logic we, input logic [1:0] sz,
                         input logic sx, input logic [9:0] a, input logic [31:0] wd);
        if (p == 0) begin
            m0_req = rq; m0_we = we; m0_size = sz; m0_sext = sx; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_req = rq; m1_we = we; m1_size = sz; m1_sext = sx; m1_addr = a; m1_wdata = wd;
        end
    endtask

    int          nwr;
    logic [9:0]  log_addr [4];
    logic [31:0] log_data [4];
    logic        log_sb   [4];
    logic        other_done;

    // Starts and ends just after a rising edge.
    task automatic do_acc(input int p, input logic we, input logic [1:0] sz, input logic sx,
                          input logic [9:0] a, input logic [31:0] wd,
                          output int lat, output logic er, output logic ok);
        int   t0;
        logic got, dn;
        nwr = 0; other_done = 1'b0; got = 1'b0; dn = 1'b0; lat = -1; er = 1'b0; t0 = 0;
        drive(p, 1'b1, we, sz, sx, a, wd);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if ((p == 0) ? m0_gnt : m1_gnt) begin
                got = 1'b1;
                t0  = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, SZ_BYTE, 1'b0, 10'h0, 32'h0);
        if (got) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (dm_we && nwr < 4) begin
                    log_addr[nwr] = dm_addr;
                    log_data[nwr] = dm_din;
                    log_sb[nwr]   = dm_issb;
                    nwr++;
                end
                if ((p == 0) ? m1_done : m0_done) other_done = 1'b1;
                if ((p == 0) ? m0_done : m1_done) begin
                    dn  = 1'b1;
                    lat = cyc - t0;
                    er  = (p == 0) ? m0_err : m1_err;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        ok = got & dn;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nwr;
    } vec_t;

    vec_t vecs [16];

    int          lat, gseq [8], dseq [8], ng, nd;
    logic        er, ok, dropped;
    logic [31:0] pre_other, act_rd, act_other;

    initial begin
        vecs[0]  = '{0, 1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1};
        vecs[1]  = '{0, 1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vecs[2]  = '{0, 1'b1, SZ_BYTE, 1'b0, 10'h020, 32'h00000080, 32'hDEADBEEF, 1'b0, 2, 1};
        vecs[3]  = '{0, 1'b0, SZ_BYTE, 1'b1, 10'h020, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
        vecs[4]  = '{0, 1'b0, SZ_BYTE, 1'b0, 10'h020, 32'h0,        32'h00000080, 1'b0, 2, 0};
        vecs[5]  = '{1, 1'b1, SZ_HALF, 1'b0, 10'h042, 32'h00001234, 32'h00000000, 1'b0, 3, 2};
        vecs[6]  = '{1, 1'b0, SZ_HALF, 1'b1, 10'h042, 32'h0,        32'h00001234, 1'b0, 3, 0};
        vecs[7]  = '{1, 1'b0, SZ_BYTE, 1'b0, 10'h043, 32'h0,        32'h00000012, 1'b0, 2, 0};
        vecs[8]  = '{0, 1'b0, SZ_WORD, 1'b0, 10'h101, 32'h0,        32'h00000080, 1'b1, 1, 0};
        vecs[9]  = '{1, 1'b0, SZ_HALF, 1'b1, 10'h003, 32'h0,        32'h00000012, 1'b1, 1, 0};
        vecs[10] = '{0, 1'b1, SZ_ILL,  1'b0, 10'h000, 32'h11223344, 32'h00000080, 1'b1, 1, 0};
        vecs[11] = '{1, 1'b1, SZ_HALF, 1'b0, 10'h060, 32'hFFFF8001, 32'h00000012, 1'b0, 3, 2};
        vecs[12] = '{1, 1'b0, SZ_HALF, 1'b1, 10'h060, 32'h0,        32'hFFFF8001, 1'b0, 3, 0};
        vecs[13] = '{1, 1'b0, SZ_HALF, 1'b0, 10'h060, 32'h0,        32'h00008001, 1'b0, 3, 0};
        vecs[14] = '{0, 1'b0, SZ_WORD, 1'b0, 10'h040, 32'h0,        32'h12340000, 1'b0, 2, 0};
        vecs[15] = '{1, 1'b1, SZ_WORD, 1'b0, 10'h101, 32'hCAFEF00D, 32'h00008001, 1'b1, 1, 0};

        rst = 1'b1; tb_clr = 1'b1;
        drive(0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 10'h0, 32'h0);
        drive(1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 10'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 m0_req = 1'b1;
        @(negedge clk);
        chk("reset ctl", {23'h0, m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err,
                          dm_we, dm_islb, dm_issb}, 32'h0);
        chk("reset dm_addr", {22'h0, dm_addr}, 32'h0);
        chk("reset dm_din", dm_din, 32'h0);
        chk("reset m0_rdata", m0_rdata, 32'h0);
        chk("reset m1_rdata", m1_rdata, 32'h0);
        @(posedge clk); #1;
        m0_req = 1'b0; rst = 1'b0; tb_clr = 1'b0;

        for (int i = 0; i < 16; i++) begin
            pre_other = (vecs[i].port == 0) ? m1_rdata : m0_rdata;
            do_acc(vecs[i].port, vecs[i].we, vecs[i].sz, vecs[i].sx, vecs[i].addr,
                   vecs[i].wd, lat, er, ok);
            act_rd    = (vecs[i].port == 0) ? m0_rdata : m1_rdata;
            act_other = (vecs[i].port == 0) ? m1_rdata : m0_rdata;
            chk($sformatf("v%0d handshake", i), {31'h0, ok}, 32'h1);
            chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d rdata", i), act_rd, vecs[i].exp_rd);
            chk($sformatf("v%0d other rdata", i), act_other, pre_other);
            chk($sformatf("v%0d other done", i), {31'h0, other_done}, 32'h0);
            chk($sformatf("v%0d write count", i), nwr, vecs[i].exp_nwr);
            if (nwr >= 1 && vecs[i].exp_nwr >= 1)
                chk($sformatf("v%0d wr0 addr", i), {22'h0, log_addr[0]}, {22'h0, vecs[i].addr});
            if (nwr == 2 && vecs[i].exp_nwr == 2) begin
                chk($sformatf("v%0d wr0 data", i), log_data[0], {24'h0, vecs[i].wd[7:0]});
                chk($sformatf("v%0d wr1 addr", i), {22'h0, log_addr[1]},
                    {22'h0, vecs[i].addr + 10'd1});
                chk($sformatf("v%0d wr1 data", i), log_data[1], {24'h0, vecs[i].wd[15:8]});
                chk($sformatf("v%0d wr byte mode", i), {30'h0, log_sb[0], log_sb[1]}, 32'h3);
            end
        end

        chk("mem 0x010", {24'h0, mem[10'h010]}, 32'hEF);
        chk("mem 0x011", {24'h0, mem[10'h011]}, 32'hBE);
        chk("mem 0x012", {24'h0, mem[10'h012]}, 32'hAD);
        chk("mem 0x013", {24'h0, mem[10'h013]}, 32'hDE);
        chk("mem 0x042", {24'h0, mem[10'h042]}, 32'h34);
        chk("mem 0x043", {24'h0, mem[10'h043]}, 32'h12);
        chk("mem 0x000 untouched", {24'h0, mem[10'h000]}, 32'h00);

        // Reset landing in the second half of a split write.
        do_acc(0, 1'b1, SZ_BYTE, 1'b0, 10'h051, 32'h00000077, lat, er, ok);
        chk("rst pre handshake", {31'h0, ok}, 32'h1);
        drive(1, 1'b1, 1'b1, SZ_HALF, 1'b0, 10'h050, 32'h0000ABCD);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (m1_gnt) begin ok = 1'b1; break; end
        end
        chk("rst gnt", {31'h0, ok}, 32'h1);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 10'h0, 32'h0);
        @(negedge clk);
        chk("rst acc0 write", {21'h0, dm_we, dm_addr}, {21'h0, 1'b1, 10'h050});
        chk("rst acc0 data", dm_din, 32'h000000CD);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst acc1 ctl", {23'h0, m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err,
                             dm_we, dm_islb, dm_issb}, 32'h0);
        chk("rst acc1 addr", {22'h0, dm_addr}, 32'h0);
        chk("rst acc1 din", dm_din, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        chk("rst low byte", {24'h0, mem[10'h050]}, 32'hCD);
        chk("rst high byte", {24'h0, mem[10'h051]}, 32'h77);
        chk("rst m0_rdata", m0_rdata, 32'h0);
        chk("rst m1_rdata", m1_rdata, 32'h0);
        do_acc(1, 1'b0, SZ_BYTE, 1'b0, 10'h051, 32'h0, lat, er, ok);
        chk("post rst handshake", {31'h0, ok}, 32'h1);
        chk("post rst latency", lat, 2);
        chk("post rst rdata", m1_rdata, 32'h00000077);

        // Both requesters held: grants must alternate starting with m0.
        drive(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0);
        drive(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 10'h040, 32'h0);
        ng = 0; nd = 0; dropped = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m0_gnt && m1_gnt) chk("cont double gnt", 32'h1, 32'h0);
            else if ((m0_gnt || m1_gnt) && ng < 8) begin gseq[ng] = m1_gnt ? 1 : 0; ng++; end
            if (m0_done && m1_done) chk("cont double done", 32'h1, 32'h0);
            else if ((m0_done || m1_done) && nd < 8) begin dseq[nd] = m1_done ? 1 : 0; nd++; end
            if (!dropped && ng == 4) begin
                @(posedge clk); #1;
                m0_req = 1'b0; m1_req = 1'b0; dropped = 1'b1;
            end
            if (nd == 4) break;
        end
        chk("cont grants", ng, 4);
        chk("cont dones", nd, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) chk($sformatf("cont gnt%0d owner", i), gseq[i], i % 2);
            if (i < nd && i < ng) chk($sformatf("cont done%0d owner", i), dseq[i], gseq[i]);
        end
        @(posedge clk); #1;
        chk("cont m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("cont m1_rdata", m1_rdata, 32'h12340000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
